// File: rtl/ask_demod_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ask_demod_ctrl
// Sequencer for the ASK demodulator: reset, FIR settle, rate acquisition,
// lock qualification with bit-activity watchdog and bounded retries.
// Rev    : 1.0
// ============================================================================
module ask_demod_ctrl #(
   parameter int SETTLE_CYC  = 4096,
   parameter int RST_CYC     = 16,
   parameter int LOCK_CNT    = 4,
   parameter int ACQ_TIMEOUT = 200000,
   parameter int WDOG_CYC    = 50000,
   parameter int RETRY_MAX   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       rate_strobe,
   input  logic [3:0] rate_in,
   input  logic       bit_valid_in,
   output logic       demod_en,
   output logic       demod_rst_n,
   output logic       locked,
   output logic [3:0] rate_kbps,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   localparam int T_MAX_A = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
   localparam int T_MAX_B = (ACQ_TIMEOUT > WDOG_CYC) ? ACQ_TIMEOUT : WDOG_CYC;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int TW      = $clog2(T_MAX + 1);
   localparam int CW      = $clog2(LOCK_CNT + 1);

   localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] ACQ_LAST    = TW'(ACQ_TIMEOUT - 1);
   localparam logic [TW-1:0] WDOG_LAST   = TW'(WDOG_CYC - 1);
   localparam logic [TW-1:0] T_SAT       = {TW{1'b1}};
   localparam logic [CW-1:0] LOCK_TGT    = CW'(LOCK_CNT);
   localparam logic [1:0]    RETRY_TGT   = 2'(RETRY_MAX);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RESET   = 3'd1,
      S_SETTLE  = 3'd2,
      S_ACQUIRE = 3'd3,
      S_LOCKED  = 3'd4,
      S_FAIL    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [CW-1:0] match_cnt_q, match_cnt_d, match_inc;
   logic [CW-1:0] mis_cnt_q, mis_cnt_d, mis_inc;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    rate_kbps_q, rate_kbps_d;
   logic [1:0]    retry_cnt_q, retry_cnt_d, retry_inc;
   logic          demod_en_q, demod_en_d;
   logic          demod_rst_n_q, demod_rst_n_d;
   logic          locked_q, locked_d;
   logic          fail_q, fail_d;
   logic          rate_ok;

   assign rate_ok   = (rate_in == 4'd6) || (rate_in == 4'd8) || (rate_in == 4'd10);
   assign timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
   assign match_inc = (match_cnt_q >= LOCK_TGT) ? match_cnt_q : match_cnt_q + 1'b1;
   assign mis_inc   = (mis_cnt_q >= LOCK_TGT) ? mis_cnt_q : mis_cnt_q + 1'b1;
   assign retry_inc = (retry_cnt_q == 2'd3) ? retry_cnt_q : retry_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_inc;
      match_cnt_d = match_cnt_q;
      mis_cnt_d   = mis_cnt_q;
      cand_d      = cand_q;
      rate_kbps_d = rate_kbps_q;
      retry_cnt_d = retry_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_RESET;
               retry_cnt_d = '0;
            end
         end
         S_RESET: begin
            if (timer_q >= RST_LAST) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (timer_q >= SETTLE_LAST) state_d = S_ACQUIRE;
         end
         S_ACQUIRE: begin
            if (rate_strobe) begin
               if (!rate_ok) begin
                  match_cnt_d = '0;
               end else if (rate_in == cand_q) begin
                  match_cnt_d = match_inc;
               end else begin
                  cand_d      = rate_in;
                  match_cnt_d = CW'(1);
               end
            end
            // A lock qualified in the timeout cycle still wins
            if (match_cnt_d >= LOCK_TGT) begin
               state_d     = S_LOCKED;
               rate_kbps_d = cand_d;
               retry_cnt_d = '0;
            end else if (timer_q >= ACQ_LAST) begin
               retry_cnt_d = retry_inc;
               state_d     = (retry_inc == RETRY_TGT) ? S_FAIL : S_RESET;
            end
         end
         S_LOCKED: begin
            if (rate_strobe && rate_ok)
               mis_cnt_d = (rate_in != rate_kbps_q) ? mis_inc : '0;
            if (mis_cnt_d >= LOCK_TGT) begin
               state_d = S_ACQUIRE;
            end else if (bit_valid_in) begin
               // Reload cycle counts as cycle 0 of the new watchdog window
               timer_d = TW'(1);
            end else if (timer_q >= WDOG_LAST) begin
               state_d = S_RESET;
            end
         end
         S_FAIL: begin
            if (start) begin
               state_d     = S_RESET;
               retry_cnt_d = '0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            retry_cnt_d = '0;
         end
      endcase

      if (abort) begin
         state_d     = S_IDLE;
         retry_cnt_d = '0;
      end

      // Every state entry restarts the phase timer and the qualification counts
      if (state_d != state_q) begin
         timer_d     = '0;
         match_cnt_d = '0;
         mis_cnt_d   = '0;
      end

      demod_en_d    = (state_d == S_ACQUIRE) || (state_d == S_LOCKED);
      demod_rst_n_d = (state_d != S_RESET);
      locked_d      = (state_d == S_LOCKED);
      fail_d        = (state_d == S_FAIL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         match_cnt_q   <= '0;
         mis_cnt_q     <= '0;
         cand_q        <= '0;
         rate_kbps_q   <= 4'd6;
         retry_cnt_q   <= '0;
         demod_en_q    <= 1'b0;
         demod_rst_n_q <= 1'b1;
         locked_q      <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         match_cnt_q   <= match_cnt_d;
         mis_cnt_q     <= mis_cnt_d;
         cand_q        <= cand_d;
         rate_kbps_q   <= rate_kbps_d;
         retry_cnt_q   <= retry_cnt_d;
         demod_en_q    <= demod_en_d;
         demod_rst_n_q <= demod_rst_n_d;
         locked_q      <= locked_d;
         fail_q        <= fail_d;
      end
   end

   assign demod_en    = demod_en_q;
   assign demod_rst_n = demod_rst_n_q;
   assign locked      = locked_q;
   assign rate_kbps   = rate_kbps_q;
   assign fail        = fail_q;
   assign retry_cnt   = retry_cnt_q;
   assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ask_demod_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ask_demod_ctrl
// Scoreboard bench: stimulus schedules expected output snapshots by cycle,
// a negedge monitor pops and compares them.
// Rev    : 1.0
// ============================================================================
module tb_ask_demod_ctrl;

   localparam int SETTLE = 64;
   localparam int RSTC   = 16;
   localparam int LOCKC  = 4;
   localparam int ACQ    = 1000;
   localparam int WDOG   = 200;
   localparam int RMAX   = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       rate_strobe = 1'b0;
   logic [3:0] rate_in = 4'd0;
   logic       bit_valid_in = 1'b0;
   logic       demod_en, demod_rst_n, locked, fail;
   logic [3:0] rate_kbps;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   ask_demod_ctrl #(
      .SETTLE_CYC (SETTLE),
      .RST_CYC    (RSTC),
      .LOCK_CNT   (LOCKC),
      .ACQ_TIMEOUT(ACQ),
      .WDOG_CYC   (WDOG),
      .RETRY_MAX  (RMAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .rate_strobe (rate_strobe),
      .rate_in     (rate_in),
      .bit_valid_in(bit_valid_in),
      .demod_en    (demod_en),
      .demod_rst_n (demod_rst_n),
      .locked      (locked),
      .rate_kbps   (rate_kbps),
      .fail        (fail),
      .retry_cnt   (retry_cnt),
      .state       (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: parallel queues kept sorted by cycle
   int          sb_cyc[$];
   logic [12:0] sb_vec[$];
   string       sb_nm[$];

   int n_cmp = 0;
   int n_bad = 0;
   logic done = 1'b0;

   function automatic logic [12:0] ev(input int st, input bit en, input bit rn,
                                      input bit lk, input int rate, input bit fl,
                                      input int rc);
      return {3'(st), en, rn, lk, 4'(rate), fl, 2'(rc)};
   endfunction

   task automatic expect_at(input int c, input logic [12:0] v, input string nm);
      int idx;
      idx = 0;
      while (idx < sb_cyc.size() && sb_cyc[idx] <= c) idx++;
      sb_cyc.insert(idx, c);
      sb_vec.insert(idx, v);
      sb_nm.insert(idx, nm);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_to(input int c);
      if (c > cyc) tick(c - cyc);
   endtask

   // One-cycle strobe; optionally expects a snapshot in the following cycle
   task automatic strobe(input int r, input bit chk, input logic [12:0] v, input string nm);
      if (chk) expect_at(cyc + 1, v, nm);
      rate_strobe = 1'b1;
      rate_in     = 4'(r);
      tick(1);
      rate_strobe = 1'b0;
      tick(3);
   endtask

   task automatic pulse_bit_at(input int c);
      tick_to(c);
      bit_valid_in = 1'b1;
      tick(1);
      bit_valid_in = 1'b0;
   endtask

   wire [12:0] dut_vec = {state, demod_en, demod_rst_n, locked, rate_kbps, fail, retry_cnt};

   always @(negedge clk) begin
      while (sb_cyc.size() > 0 && (done || sb_cyc[0] <= cyc)) begin
         n_cmp = n_cmp + 1;
         if (done || sb_cyc[0] < cyc) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: check for cycle %0d not reached (now %0d)", sb_nm[0], sb_cyc[0], cyc);
         end else if (dut_vec !== sb_vec[0]) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cyc %0d: got {st,en,rn,lk,rate,fl,rc}=%h, want %h",
                     sb_nm[0], cyc, dut_vec, sb_vec[0]);
         end
         void'(sb_cyc.pop_front());
         void'(sb_vec.pop_front());
         void'(sb_nm.pop_front());
      end
   end

   initial begin
      int t, l, w, c2, f, r;
      int seq_a[9]  = '{8, 8, 6, 6, 9, 6, 6, 6, 6};
      int seq_m[7]  = '{10, 10, 6, 10, 7, 10, 10};

      tick(3);
      rst_n = 1'b1;
      tick(2);
      expect_at(cyc, ev(0, 0, 1, 0, 6, 0, 0), "reset_state");
      tick(2);

      // Start sequence
      t = cyc;
      expect_at(t,                 ev(0, 0, 1, 0, 6, 0, 0), "pre_start");
      expect_at(t + 1,             ev(1, 0, 0, 0, 6, 0, 0), "rst_first");
      expect_at(t + RSTC,          ev(1, 0, 0, 0, 6, 0, 0), "rst_last");
      expect_at(t + RSTC + 1,      ev(2, 0, 1, 0, 6, 0, 0), "settle_first");
      expect_at(t + RSTC + SETTLE, ev(2, 0, 1, 0, 6, 0, 0), "settle_last");
      expect_at(t + RSTC + SETTLE + 1, ev(3, 1, 1, 0, 6, 0, 0), "acq_enter");
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick_to(t + RSTC + SETTLE + 2);

      // Lock: 8,8,6,6, invalid 9 clears count, then four 6s lock
      for (int i = 0; i < 9; i++) begin
         if (i == 8) expect_at(cyc, ev(3, 1, 1, 0, 6, 0, 0), "lock_pre");
         if (i == 8) l = cyc + 1;
         strobe(seq_a[i], (i == 7) || (i == 8),
                (i == 8) ? ev(4, 1, 1, 1, 6, 0, 0) : ev(3, 1, 1, 0, 6, 0, 0),
                (i == 8) ? "lock_6" : "no_lock_after_9");
      end

      // Watchdog: reloads every 150, one reload exactly on expiry, then silence
      expect_at(l + 199, ev(4, 1, 1, 1, 6, 0, 0), "wdog_hold1");
      expect_at(l + 398, ev(4, 1, 1, 1, 6, 0, 0), "wdog_hold2");
      expect_at(l + 600, ev(4, 1, 1, 1, 6, 0, 0), "wdog_coincide");
      expect_at(l + 798, ev(4, 1, 1, 1, 6, 0, 0), "wdog_last");
      expect_at(l + 799, ev(1, 0, 0, 0, 6, 0, 0), "wdog_expire");
      expect_at(l + 879, ev(3, 1, 1, 0, 6, 0, 0), "reacq_after_wdog");
      pulse_bit_at(l + 100);
      pulse_bit_at(l + 250);
      pulse_bit_at(l + 400);
      pulse_bit_at(l + 599);
      tick_to(l + 880);

      // Rate change while locked
      for (int i = 0; i < 4; i++)
         strobe(6, i == 3, ev(4, 1, 1, 1, 6, 0, 0), "relock_6");
      for (int i = 0; i < 7; i++)
         strobe(seq_m[i], i == 6, ev(4, 1, 1, 1, 6, 0, 0), "mis_not_yet");
      strobe(10, 1'b1, ev(3, 1, 1, 0, 6, 0, 0), "unlock_10");
      for (int i = 0; i < 4; i++)
         strobe(10, (i == 2) || (i == 3),
                (i == 3) ? ev(4, 1, 1, 1, 10, 0, 0) : ev(3, 1, 1, 0, 6, 0, 0),
                (i == 3) ? "lock_10" : "acq_3_of_10");

      // Abort while locked, then abort in SETTLE
      expect_at(cyc + 1, ev(0, 0, 1, 0, 10, 0, 0), "abort_locked");
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(2);
      w = cyc;
      expect_at(w + 30, ev(2, 0, 1, 0, 10, 0, 0), "settle_pre_abort");
      expect_at(w + 31, ev(0, 0, 1, 0, 10, 0, 0), "abort_settle");
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick_to(w + 30);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(3);

      // Retry to FAIL with a stray start ignored during ACQUIRE
      c2 = cyc;
      expect_at(c2 + 1080, ev(3, 1, 1, 0, 10, 0, 0), "acq1_last");
      expect_at(c2 + 1081, ev(1, 0, 0, 0, 10, 0, 1), "retry1");
      expect_at(c2 + 2161, ev(1, 0, 0, 0, 10, 0, 2), "retry2");
      expect_at(c2 + 3240, ev(3, 1, 1, 0, 10, 0, 2), "acq3_last");
      expect_at(c2 + 3241, ev(5, 0, 1, 0, 10, 1, 3), "fail");
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick_to(c2 + 500);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick_to(c2 + 3245);
      f = cyc;
      expect_at(f,     ev(5, 0, 1, 0, 10, 1, 3), "fail_hold");
      expect_at(f + 1, ev(1, 0, 0, 0, 10, 0, 0), "restart_from_fail");
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick_to(f + RSTC + SETTLE + 2);

      // Lock at 8, then asynchronous reset mid-cycle
      for (int i = 0; i < 4; i++)
         strobe(8, i == 3, ev(4, 1, 1, 1, 8, 0, 0), "lock_8");
      r = cyc;
      expect_at(r,     ev(0, 0, 1, 0, 6, 0, 0), "async_rst");
      expect_at(r + 1, ev(0, 0, 1, 0, 6, 0, 0), "async_rst_hold");
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(5);

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
